// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter
// and its FIFO-side neighbours.
package fifo_wr_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Bits needed to index n items; never below 1.
  function automatic int clog2_w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Binary to Gray code for FIFO pointer crossings.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or
// after the start index, wrapping modulo N.
module fifo_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] start,
  output logic          found,
  output logic [GW-1:0] idx
);

  // Scan from farthest offset down so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(start) + i) % N]) begin
        found = 1'b1;
        idx   = GW'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NREQ producers,
// round-robin with bounded bursts and full gating.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  localparam int GW   = clog2_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_winc,
  output logic [WIDTH-1:0]      fifo_wdata,
  input  logic                  fifo_wfull,
  output logic [GW-1:0]         grant_id,
  output logic                  busy
);

  localparam int CW = clog2_w(BURST + 1);

  logic [0:0]    state;
  logic [GW-1:0] gnt;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] cnt;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          in_grant;
  logic          vld_g;
  logic          accept;
  logic [GW-1:0] gnt_inc;
  logic [CW-1:0] cnt_inc;
  logic          burst_done;

  fifo_wr_arbiter_rr_pick #(
    .N  (NREQ),
    .GW (GW)
  ) u_rr_pick (
    .req   (req_valid),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_grant   = (state == ST_GRANT);
  assign vld_g      = req_valid[gnt];
  // Full gating: the SRAM write enable is not
  // qualified by full inside the FIFO.
  assign accept     = in_grant & vld_g & ~fifo_wfull;
  assign gnt_inc    = (int'(gnt) == NREQ - 1) ?
                      '0 : gnt + GW'(1);
  assign cnt_inc    = cnt + CW'(1);
  assign burst_done = (cnt_inc == CW'(BURST));

  assign fifo_winc  = accept;
  assign req_ready  = accept ?
                      (NREQ'(1) << gnt) : '0;
  assign fifo_wdata = in_grant ?
                      req_data[int'(gnt)*WIDTH +: WIDTH] :
                      '0;
  assign grant_id   = gnt;
  assign busy       = in_grant;

  // Arbitration FSM; grant holds through any wfull stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_found) begin
            gnt   <= pick_idx;
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!fifo_wfull) begin
            if (vld_g) begin
              cnt <= cnt_inc;
              if (burst_done) begin
                state  <= ST_IDLE;
                rr_ptr <= gnt_inc;
              end
            end else begin
              state  <= ST_IDLE;
              rr_ptr <= gnt_inc;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised bench for fifo_wr_arbiter against a
// queue-based producer/arbiter/FIFO model.
module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int B  = 4;
  localparam int GW = 2;
  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         fifo_winc;
  logic [W-1:0] fifo_wdata;
  logic         fifo_wfull;
  logic [GW-1:0] grant_id;
  logic         busy;

  fifo_wr_arbiter #(
    .WIDTH (W),
    .NREQ  (N),
    .BURST (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q [N][$];
  logic [W-1:0] exp_wr [$];
  logic [W-1:0] dut_wr [$];
  logic [N-1:0] en;
  logic stall;
  logic use_fifo;
  logic ffull;
  int   fcnt;

  // model: owner<0 means no grant outstanding
  int m_owner;
  int m_taken;
  int m_next;
  int m_gid;

  always @(negedge clk)
    if (fifo_winc) dut_wr.push_back(fifo_wdata);

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (q[i].size() > 0);
      req_data[i*W +: W] = req_valid[i] ? q[i][0] : '0;
    end
    fifo_wfull = stall | (use_fifo & ffull);
  endtask

  function automatic logic [15:0] model_out();
    logic acc;
    logic [N-1:0] rdy;
    logic [W-1:0] wd;
    acc = (m_owner >= 0) && req_valid[m_owner]
          && !fifo_wfull;
    rdy = acc ? (4'b0001 << m_owner) : 4'b0000;
    wd  = (m_owner >= 0) ?
          req_data[m_owner*W +: W] : 8'h00;
    return {rdy, acc, wd, 2'(m_gid), m_owner >= 0};
  endfunction

  task automatic commit();
    logic acc;
    int k;
    acc = (m_owner >= 0) && req_valid[m_owner]
          && !fifo_wfull;
    if (m_owner < 0) begin
      for (int s = 0; s < N; s++) begin
        k = (m_next + s) % N;
        if (req_valid[k]) begin
          m_owner = k;
          m_gid   = k;
          m_taken = 0;
          break;
        end
      end
    end else if (!fifo_wfull) begin
      if (acc) begin
        exp_wr.push_back(q[m_owner].pop_front());
        fcnt++;
        m_taken++;
      end
      if (!acc || m_taken == B) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    ffull = use_fifo && (fcnt >= DEPTH);
  endtask

  task automatic step();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_taken = 0;
    m_next  = 0;
    m_gid   = 0;
  endtask

  task automatic do_reset();
    en = '0;
    stall = 1'b0;
    use_fifo = 1'b0;
    ffull = 1'b0;
    fcnt = 0;
    for (int i = 0; i < N; i++) q[i].delete();
    apply();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_wr.delete();
    dut_wr.delete();
  endtask

  function automatic logic [15:0] dut_out();
    return {req_ready, fifo_winc, fifo_wdata,
            grant_id, busy};
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++)
        q[i].push_back(W'($urandom));
    en = '1;
    stall = 1'b0;
    use_fifo = 1'b0;
    apply();
    rst_n = 1'b0;
    model_reset();
    #2;
    got = dut_out();
    total++;
    if (got !== 16'h0) begin
      bad++;
      $display("FAIL reset_async got=%h exp=0000", got);
    end
    repeat (2) @(posedge clk);
    #1;
    got = dut_out();
    total++;
    if (got !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0000", got);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] words [6];
    logic [9:0] hist;
    logic [9:0] want;
    logic [15:0] got;
    logic [15:0] exp;
    do_reset();
    want = 10'b0111101100;
    for (int i = 0; i < 6; i++) begin
      words[i] = W'($urandom);
      q[0].push_back(words[i]);
    end
    en = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      apply();
      @(negedge clk);
      got = dut_out();
      exp = model_out();
      hist[9-c] = fifo_winc;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single c=%0d got=%h exp=%h",
                 c, got, exp);
      end
      step();
    end
    total++;
    if (hist !== want) begin
      bad++;
      $display("FAIL single_winc got=%b exp=%b",
               hist, want);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (dut_wr.size() != 6 || dut_wr[i] !== words[i]) begin
        bad++;
        $display("FAIL single_data i=%0d n=%0d exp=%h",
                 i, dut_wr.size(), words[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int starts [$];
    int want [5];
    int per [N];
    logic prev;
    logic [15:0] got;
    logic [15:0] exp;
    do_reset();
    want = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++)
        q[i].push_back({2'(i), 6'($urandom)});
    en = '1;
    prev = 1'b0;
    for (int c = 0; c < 25; c++) begin
      apply();
      @(negedge clk);
      got = dut_out();
      exp = model_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rr c=%0d got=%h exp=%h",
                 c, got, exp);
      end
      if (busy && !prev) starts.push_back(int'(grant_id));
      prev = busy;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (starts.size() != 5 || starts[i] != want[i]) begin
        bad++;
        $display("FAIL rr_order i=%0d n=%0d exp=%0d",
                 i, starts.size(), want[i]);
      end
    end
    per = '{0, 0, 0, 0};
    foreach (dut_wr[i]) per[dut_wr[i][7:6]]++;
    for (int i = 0; i < N; i++) begin
      total++;
      if (per[i] != ((i == 0) ? 8 : 4)) begin
        bad++;
        $display("FAIL rr_words id=%0d got=%0d exp=%0d",
                 i, per[i], (i == 0) ? 8 : 4);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] words [4];
    logic [15:0] got;
    logic [15:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      words[i] = W'($urandom);
      q[1].push_back(words[i]);
    end
    en = 4'b0010;
    for (int c = 0; c < 17; c++) begin
      stall = (c >= 3) && (c < 13);
      apply();
      @(negedge clk);
      got = dut_out();
      exp = model_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL stall c=%0d got=%h exp=%h",
                 c, got, exp);
      end
      if (stall) begin
        total++;
        if (fifo_winc !== 1'b0 || req_ready !== 4'b0 ||
            busy !== 1'b1 || grant_id !== 2'd1) begin
          bad++;
          $display("FAIL stall_hold c=%0d winc=%b rdy=%b busy=%b gid=%0d exp=0/0/1/1",
                   c, fifo_winc, req_ready, busy, grant_id);
        end
      end
      step();
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_wr.size() != 4 || dut_wr[i] !== words[i]) begin
        bad++;
        $display("FAIL stall_data i=%0d n=%0d exp=%h",
                 i, dut_wr.size(), words[i]);
      end
    end
  endtask

  task automatic test_early_release(input bit alt);
    int starts [$];
    int want [2];
    logic prev;
    logic [15:0] got;
    logic [15:0] exp;
    do_reset();
    want = alt ? '{2, 0} : '{2, 3};
    q[2].push_back(W'($urandom));
    if (alt) begin
      q[0].push_back(W'($urandom));
      en = 4'b0100;
    end else begin
      q[3].push_back(W'($urandom));
      q[3].push_back(W'($urandom));
      en = 4'b1100;
    end
    prev = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (alt && c == 2) en[0] = 1'b1;
      apply();
      @(negedge clk);
      got = dut_out();
      exp = model_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL early c=%0d got=%h exp=%h",
                 c, got, exp);
      end
      if (busy && !prev) starts.push_back(int'(grant_id));
      prev = busy;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (starts.size() != 2 || starts[i] != want[i]) begin
        bad++;
        $display("FAIL early_order alt=%0d i=%0d n=%0d exp=%0d",
                 alt, i, starts.size(), want[i]);
      end
    end
  endtask

  task automatic test_fifo_fill();
    logic [15:0] got;
    logic [15:0] exp;
    int full_writes;
    do_reset();
    use_fifo = 1'b1;
    full_writes = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 20; j++)
        q[i].push_back(W'($urandom));
    en = '1;
    for (int c = 0; c < 110; c++) begin
      apply();
      @(negedge clk);
      got = dut_out();
      exp = model_out();
      if (fifo_winc && fifo_wfull) full_writes++;
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL fill c=%0d got=%h exp=%h",
                 c, got, exp);
      end
      step();
    end
    total++;
    if (dut_wr.size() != DEPTH) begin
      bad++;
      $display("FAIL fill_count got=%0d exp=%0d",
               dut_wr.size(), DEPTH);
    end
    total++;
    if (full_writes != 0) begin
      bad++;
      $display("FAIL fill_overrun got=%0d exp=0",
               full_writes);
    end
    total++;
    if (dut_wr != exp_wr) begin
      bad++;
      $display("FAIL fill_drain got_n=%0d exp_n=%0d",
               dut_wr.size(), exp_wr.size());
    end
    use_fifo = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    logic [15:0] exp;
    do_reset();
    for (int j = 0; j < 4; j++)
      q[1].push_back(W'($urandom));
    en = 4'b0010;
    apply();
    @(negedge clk);
    step();
    apply();
    @(negedge clk);
    total++;
    if (fifo_winc !== 1'b1) begin
      bad++;
      $display("FAIL mid_accept got=%b exp=1", fifo_winc);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = dut_out();
    total++;
    if (got !== 16'h0) begin
      bad++;
      $display("FAIL mid_async got=%h exp=0000", got);
    end
    q[0].push_back(W'($urandom));
    q[0].push_back(W'($urandom));
    en = 4'b0011;
    apply();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 6; c++) begin
      apply();
      @(negedge clk);
      got = dut_out();
      exp = model_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL mid c=%0d got=%h exp=%h",
                 c, got, exp);
      end
      if (c == 0) begin
        total++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
          bad++;
          $display("FAIL mid_first busy=%b gid=%0d exp=1/0",
                   busy, grant_id);
        end
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [15:0] got;
    logic [15:0] exp;
    do_reset();
    en = '1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0)
          q[i].push_back(W'($urandom));
        if ($urandom_range(0, 5) == 0)
          en[i] = ~en[i];
      end
      stall = ($urandom_range(0, 6) == 0);
      apply();
      @(negedge clk);
      got = dut_out();
      exp = model_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random c=%0d got=%h exp=%h",
                 c, got, exp);
      end
      step();
    end
    stall = 1'b0;
    total++;
    if (dut_wr != exp_wr) begin
      bad++;
      $display("FAIL random_stream got_n=%0d exp_n=%0d",
               dut_wr.size(), exp_wr.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = '0;
    stall = 1'b0;
    use_fifo = 1'b0;
    ffull = 1'b0;
    fcnt = 0;
    model_reset();
    apply();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_early_release(1'b0);
    test_early_release(1'b1);
    test_fifo_fill();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
